// File: rtl/aes_sbox_pkg.sv
// Shared definitions for the AES SubBytes sequencer.
//   seq_state_t : sequencer states IDLE / FEED / DRAIN / DONE
//   NBYTES      : bytes in a full 128-bit state
//   WBYTES      : bytes in a key-schedule word (SubWord)
//   IDX_W       : width of a byte index
//   sbox_tag_t  : tag that travels alongside each byte inside the S-box pipe
package aes_sbox_pkg;

  localparam int NBYTES = 16;
  localparam int WBYTES = 4;
  localparam int IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } sbox_tag_t;

endpackage

// File: rtl/sbox.sv
// Pipelined AES S-box.
//   clk : clock
//   in  : byte to substitute
//   out : S(in), available LAT rising edges after in is applied
// The substitution is computed as the GF(2^8) inverse (x^254) followed by
// the AES affine transform. No reset: the pipe carries data only.
module sbox #(
  parameter int LAT = 2
) (
  input  logic       clk,
  input  logic [7:0] in,
  output logic [7:0] out
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 as AES requires.
  function automatic logic [7:0] sub_byte(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [7:0] pipe_p [LAT];

  // stage 0 substitutes, later stages only delay
  always_ff @(posedge clk) begin
    pipe_p[0] <= sub_byte(in);
    for (int i = 1; i < LAT; i++) pipe_p[i] <= pipe_p[i-1];
  end

  assign out = pipe_p[LAT-1];

endmodule

// File: rtl/sbox_tag_pipe.sv
// Shift register that keeps one tag per byte in flight through the S-box.
//   clk     : clock
//   rst_n   : asynchronous active-low clear of every stage
//   tag_in  : tag entering together with the S-box input byte
//   tag_out : tag leaving together with the S-box output byte
module sbox_tag_pipe
  import aes_sbox_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  sbox_tag_t tag_in,
  output sbox_tag_t tag_out
);

  sbox_tag_t stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/aes_subbytes_seq.sv
// AES SubBytes sequencer: streams the 16 bytes of a state through one shared
// pipelined S-box and reassembles the result in place.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake, in_ready only in IDLE
//   in_state            : 128-bit state, byte k = in_state[8k+7:8k]
//   in_word             : (SBOX_SUBWORD_EN only) SubWord, bytes 0..3 only
//   out_valid/out_ready : output handshake, out_valid only in DONE
//   out_state           : substituted state (zero while out_valid is low)
//   busy                : job in progress (FEED, DRAIN or DONE)
// Optional feature macro: SBOX_SUBWORD_EN.
module aes_subbytes_seq
  import aes_sbox_pkg::*;
#(
  parameter int SBOX_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
`ifdef SBOX_SUBWORD_EN
  input  logic         in_word,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam logic [IDX_W-1:0] LAST_FULL = IDX_W'(NBYTES - 1);
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(WBYTES - 1);

  seq_state_t       state;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] job_last;
  logic [127:0]     result;
  logic [7:0]       sbox_in;
  logic [7:0]       sbox_out;
  sbox_tag_t        tag_in;
  sbox_tag_t        tag_out;
  logic             word_sel;
  logic             accept;
  logic             last_issue;
  logic             last_return;

`ifdef SBOX_SUBWORD_EN
  assign word_sel = in_word;
`else
  assign word_sel = 1'b0;
`endif

  assign job_last    = word_sel ? LAST_WORD : LAST_FULL;
  assign accept      = in_valid && in_ready;
  assign last_issue  = (cnt == last_idx);
  assign last_return = tag_out.valid && (tag_out.idx == last_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      last_idx <= LAST_FULL;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= FEED;
            cnt      <= '0;
            last_idx <= job_last;
          end
        end
        FEED: begin
          cnt <= last_issue ? '0 : cnt + IDX_W'(1);
          if (last_issue) state <= DRAIN;
        end
        DRAIN: begin
          if (last_return) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result is updated in place: bytes are read in FEED at cnt and written
  // back at the returning tag index, which always lags cnt.
  always_ff @(posedge clk) begin
    if (accept) begin
      result <= in_state;
    end else if (tag_out.valid) begin
      result[{tag_out.idx, 3'b000} +: 8] <= sbox_out;
    end
  end

  // issue stage: byte and tag enter the S-box pipe together
  assign sbox_in      = (state == FEED) ? result[{cnt, 3'b000} +: 8] : 8'h00;
  assign tag_in.valid = (state == FEED);
  assign tag_in.idx   = cnt;

  sbox #(
    .LAT (SBOX_LAT)
  ) u_sbox (
    .clk (clk),
    .in  (sbox_in),
    .out (sbox_out)
  );

  sbox_tag_pipe #(
    .DEPTH (SBOX_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // return stage: tag_out/sbox_out retire into result above
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_state = out_valid ? result : 128'd0;

endmodule

// File: doc/aes_subbytes_seq.md
# aes_subbytes_seq

Sequencer that applies the AES S-box to a full 128-bit state using one shared pipelined `sbox` instance. It streams one byte per cycle into the S-box and tracks bytes in flight with a tag pipeline. Output bytes are reassembled in place, and the result is presented with a valid/ready handshake. It sits between the round controller and the S-box and provides the SubBytes step; when `SBOX_SUBWORD_EN` is defined it also provides the key-schedule SubWord step.

## Interface
- `SBOX_LAT`, 2: pipeline depth of the instantiated `sbox`, counted in clock edges from `in` to `out`. Must equal the real S-box depth. Legal range 1..4.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: `in_state` is valid.
- `in_ready` output 1: block can accept a state; high only in IDLE.
- `in_state` input 128: state to substitute; byte k = `in_state[8k+7:8k]`.
- `in_word` input 1: present only with `SBOX_SUBWORD_EN`; 1 selects SubWord (bytes 0..3 only).
- `out_valid` output 1: `out_state` holds the result.
- `out_ready` input 1: consumer accepts the result.
- `out_state` output 128: substituted state; byte k = S(in byte k).
- `busy` output 1: high in FEED, DRAIN or DONE.

## Operation
- States are IDLE, FEED, DRAIN and DONE.
- **IDLE:** `in_ready`=1. A handshake (`in_valid` & `in_ready`) on an edge has these effects:
  - captures `in_state` into the result register;
  - clears the issue counter;
  - moves to FEED.
- **FEED:** each cycle, byte at index `cnt` drives the S-box input.
  - A tag {valid=1, idx=`cnt`} enters a `SBOX_LAT`-deep shift register; `cnt` increments.
  - After the last index issued (15, or 3 in word mode), go to DRAIN.
- **DRAIN:** S-box input is held at 8'h00 and the tags entering are invalid.
  - Whenever the tag leaving the pipe is valid, S-box `out` is written into result byte `idx`.
  - When the last valid tag has left, go to DONE.
- **DONE:** `out_valid`=1 and `out_state` is stable. On `out_ready` go to IDLE with `out_valid`=0.
- Outside FEED the S-box input is 8'h00. Tags are written in every state; an invalid tag never writes the result.
- The result register is updated in place. Bytes not yet returned hold their input value, and this is not visible while `out_valid`=0.
- `in_valid` is ignored outside IDLE. `out_ready` is ignored outside DONE.
- **Reset:** asynchronous assertion at any time, including mid-FEED or mid-DRAIN, has these effects:
  - state goes to IDLE;
  - `cnt`=0 and all tag valids are cleared, so in-flight S-box outputs are discarded;
  - `in_ready`=0 while `rst_n`=0 and 1 after release;
  - `out_valid`=0, `busy`=0, `out_state`=0.

## Timing
- Take the accept edge as edge 0.
- Byte k enters the S-box in the cycle after edge k. Its result is written on edge k+1+`SBOX_LAT`.
- For a 16-byte job, the final write is on edge 16+`SBOX_LAT`.
  - DONE is entered on that edge, so `out_valid` is high from edge 16+`SBOX_LAT` (18 for the default).
- For a 4-byte word job, `out_valid` is high from edge 4+`SBOX_LAT`.
- With `out_ready` held high, DONE lasts one cycle and `in_ready` returns on the following edge.
- Minimum spacing between accepts is therefore 18+`SBOX_LAT` edges (20 for the default). There is no overlap of jobs.
- `in_ready`, `out_valid` and `busy` are registered-state decodes and are glitch-free.

## Configuration
- `SBOX_SUBWORD_EN` defined: the `in_word` port exists and is sampled at accept.
  - Word mode issues only bytes 0..3.
  - Bits 127:32 of `out_state` equal the captured input unchanged.
- `SBOX_SUBWORD_EN` undefined: the port is absent and every job is 16 bytes.

## Structure
- Shared package `aes_sbox_pkg` holds:
  - state enum `seq_state_t` (IDLE, FEED, DRAIN, DONE);
  - constants `NBYTES`=16, `WBYTES`=4, `IDX_W`=4;
  - tag struct `sbox_tag_t` {valid, idx[3:0]}.
- Sub-module `sbox_tag_pipe` is a `SBOX_LAT`-deep shift register of `sbox_tag_t` with async clear.
- The existing `sbox` (ports `in`, `out`, `clk`) is instantiated once.

## Test plan
- **All-zero state:** `in_state`=0 → `out_state`=128'h6363…63 (16 bytes of 63); `out_valid` is high from edge 18 exactly.
- **FIPS-197 round 1:**
  - Bytes 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08 map to d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30.
  - Check this for every byte position.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after `out_valid` rises → result stable, `in_ready`=0, a new `in_valid` is ignored. Release → next accept one edge later.
- **Back-to-back jobs:**
  - Job 1 bytes all 01, job 2 bytes all ff, with `out_ready`=1 throughout.
  - Expected results: 7c…7c, then 16…16; accepts 20 edges apart.
- **Reset mid-FEED:** assert `rst_n`=0 at edge 7, release, then send 53…53.
  - All outputs are zero during reset.
  - The job produces ed…ed with no stale bytes.
- **Word mode (`SBOX_SUBWORD_EN`):** `in_word`=1, `in_state`=…_cf4f3c09 → low word 8a84eb01, upper 96 bits unchanged, `out_valid` at edge 6.
